// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8 x 8 synchronous FIFO, its interface
// and its testbench.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_CNT_WIDTH  = 4;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_CNT_WIDTH-1:0]  fifo_cnt_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo_if.sv
// FIFO request/response bundle. The driver side is the master; the FIFO
// itself is the slave that samples requests and returns data and status.
interface sync_fifo_if;
  import fifo_pkg::*;

  logic       wr;
  fifo_data_t data_in;
  logic       rd;
  fifo_data_t data_out;
  logic       full;
  logic       empty;
  fifo_cnt_t  fifo_cnt;
  logic       overflow;
  logic       underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, full, empty, fifo_cnt, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, full, empty, fifo_cnt, overflow, underflow
  );

endinterface : sync_fifo_if

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port and one registered
// read port. The array is never cleared; only the read register resets.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered output that holds its value when no read occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller: pointers, occupancy counter, accept logic,
// status flags and one-cycle overflow/underflow pulses around fifo_mem.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        wp_reg, wp_next;
  logic [AW-1:0]        rp_reg, rp_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 overflow_reg, underflow_reg;
  logic                 full_flag, empty_flag;
  logic                 rd_ok, wr_ok;
  logic                 mem_we, mem_re;

  // Flags are decoded from the registered count, so no input reaches an output.
  assign full_flag  = (cnt_reg == CNT_WIDTH'(DEPTH));
  assign empty_flag = (cnt_reg == '0);

  // A read frees a slot in the same cycle, so a full FIFO may still accept a
  // write alongside a read. An empty FIFO never bypasses write data to a read.
  assign rd_ok = bus.rd && !empty_flag;
  assign wr_ok = bus.wr && (!full_flag || rd_ok);

  // Reset discards any request presented at the same edge.
  assign mem_we = wr_ok && !rst;
  assign mem_re = rd_ok && !rst;

  // Next-state for pointers and occupancy; pointers wrap naturally (power of two).
  always_comb begin
    wp_next  = wp_reg;
    rp_next  = rp_reg;
    cnt_next = cnt_reg;
    if (wr_ok) begin
      wp_next = wp_reg + 1'b1;
    end
    if (rd_ok) begin
      rp_next = rp_reg + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // State registers and the registered drop indications.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      cnt_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      cnt_reg       <= cnt_next;
      overflow_reg  <= bus.wr && !wr_ok;
      underflow_reg <= bus.rd && !rd_ok;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wp_reg),
    .wdata (bus.data_in),
    .re    (mem_re),
    .raddr (rp_reg),
    .rdata (bus.data_out)
  );

  assign bus.full      = full_flag;
  assign bus.empty     = empty_flag;
  assign bus.fifo_cnt  = cnt_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo: ordering, fill/overflow, empty reads,
// full read+write, pointer wrap and reset in the middle of traffic.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sync_fifo_if bus();

  sync_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request set, let one rising edge take it, then sample 1 time unit later.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bus.wr      = w;
    bus.data_in = d;
    bus.rd      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] dout, input int cnt,
                             input logic ovf, input logic unf);
    check({tag, " data_out"},  32'(bus.data_out), 32'(dout));
    check({tag, " fifo_cnt"},  32'(bus.fifo_cnt), 32'(cnt));
    check({tag, " full"},      32'(bus.full),     32'(cnt == 8));
    check({tag, " empty"},     32'(bus.empty),    32'(cnt == 0));
    check({tag, " overflow"},  32'(bus.overflow), 32'(ovf));
    check({tag, " underflow"}, 32'(bus.underflow),32'(unf));
    $display("[TB] %s: dout=%02h cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b", tag,
             bus.data_out, bus.fifo_cnt, bus.full, bus.empty, bus.overflow, bus.underflow);
  endtask

  initial begin
    logic [7:0] exp_a [3];
    tests_run    = 0;
    tests_failed = 0;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    bus.data_in  = '0;

    // Reset
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    check_state("reset", 8'h00, 0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Basic ordering: 11, 22, 33 in, then out
    exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, exp_a[i], 1'b0);
      check_state("order_wr", 8'h00, i + 1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check_state("order_rd", exp_a[i], 2 - i, 1'b0, 1'b0);
    end

    // Fill 00..07, then a dropped 9th write of AA
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      check_state("fill_wr", 8'h33, i + 1, 1'b0, 1'b0);
    end
    cyc(1'b1, 8'hAA, 1'b0);
    check_state("ovf_pulse", 8'h33, 8, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check_state("ovf_clear", 8'h33, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check_state("fill_drain", 8'(i), 7 - i, 1'b0, 1'b0);
    end

    // Empty read, then write+read while empty
    cyc(1'b0, 8'h00, 1'b1);
    check_state("unf_pulse", 8'h07, 0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check_state("unf_clear", 8'h07, 0, 1'b0, 1'b0);
    cyc(1'b1, 8'h5C, 1'b1);
    check_state("empty_wr_rd", 8'h07, 1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check_state("empty_rd_back", 8'h5C, 0, 1'b0, 1'b0);

    // Full with simultaneous read and write of F0
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
    end
    check_state("refill", 8'h5C, 8, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b1);
    check_state("full_wr_rd", 8'h00, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check_state("full_drain", (i == 7) ? 8'hF0 : 8'(i + 1), 7 - i, 1'b0, 1'b0);
    end

    // Pointer wrap: one pre-write, then 20 cycles of write+read
    cyc(1'b1, 8'h40, 1'b0);
    check_state("wrap_pre", 8'hF0, 1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 8'(8'h40 + k), 1'b1);
      check_state("wrap", 8'(8'h40 + k - 1), 1, 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    check_state("wrap_last", 8'h54, 0, 1'b0, 1'b0);

    // Reset mid-operation with 5 words stored and wr/rd high
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(8'h61 + i), 1'b0);
    end
    check_state("pre_rst", 8'h54, 5, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h66, 1'b1);
    check_state("mid_rst", 8'h00, 0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    check_state("post_rst_wr", 8'h00, 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check_state("post_rst_rd", 8'h77, 0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check_state("post_rst_unf", 8'h77, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sync_fifo
